// File: rtl/byte_to_word_packer.sv
// byte_to_word_packer
//   Packs a byte stream little-endian into words and issues one-cycle word
//   writes with per-lane byte enables. Used to load program/data memory from
//   a serial byte source. Supports an unaligned start address, a partial-word
//   flush, and automatic termination at the top of the byte address space.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a session at start_addr (only honoured when idle)
//   start_addr      first byte address of the session
//   flush           write out any partial word and end the session
//   byte_valid      byte_data holds a byte
//   byte_data       incoming byte
//   byte_ready      a byte is accepted this cycle when byte_valid is also high
//   word_we         one-cycle word write strobe
//   word_addr_out   word address of the write
//   word_data_out   assembled word, unwritten lanes are zero
//   word_be         per-lane byte enable, lane i = bits [8i+7:8i]
//   busy            session in progress
//   done            one-cycle pulse when the session returns to idle
module byte_to_word_packer #(
   parameter int BYTE_ADDR_WIDTH = 6,
   parameter int BYTES_PER_WORD  = 4
) (
   input  logic                                                    clk,
   input  logic                                                    rst,
   input  logic                                                    start,
   input  logic [BYTE_ADDR_WIDTH-1:0]                              start_addr,
   input  logic                                                    flush,
   input  logic                                                    byte_valid,
   input  logic [7:0]                                              byte_data,
   output logic                                                    byte_ready,
   output logic                                                    word_we,
   output logic [BYTE_ADDR_WIDTH-$clog2(BYTES_PER_WORD)-1:0]       word_addr_out,
   output logic [8*BYTES_PER_WORD-1:0]                             word_data_out,
   output logic [BYTES_PER_WORD-1:0]                               word_be,
   output logic                                                    busy,
   output logic                                                    done
);

   localparam int BYTES_PER_WORD_LOG2 = $clog2(BYTES_PER_WORD);
   localparam int BITS_PER_WORD       = 8 * BYTES_PER_WORD;
   localparam int WORD_ADDR_WIDTH     = BYTE_ADDR_WIDTH - BYTES_PER_WORD_LOG2;
   localparam logic [BYTES_PER_WORD_LOG2-1:0] LAST_LANE =
      BYTES_PER_WORD_LOG2'(BYTES_PER_WORD - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]                           state, state_n;
   logic [BYTE_ADDR_WIDTH-1:0]           byte_addr;
   logic [BITS_PER_WORD-1:0]             data_q;
   logic [BYTES_PER_WORD-1:0]            be_q;
   logic [WORD_ADDR_WIDTH-1:0]           waddr_q;
   logic                                 flush_pend;
   logic                                 end_hit;
   logic                                 done_q;

   logic [BYTES_PER_WORD_LOG2-1:0]       lane;
   logic                                 xfer;
   logic                                 at_top;

   assign lane   = byte_addr[BYTES_PER_WORD_LOG2-1:0];
   assign at_top = &byte_addr;
   assign xfer   = byte_valid && (state == S_FILL);

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (start) state_n = S_FILL;
         S_FILL: begin
            // A completed word (or the last byte of memory) takes priority;
            // a coincident flush is remembered via flush_pend below.
            if (xfer && (lane == LAST_LANE || at_top))
               state_n = S_WRITE;
            else if (flush)
               state_n = (xfer || be_q != '0) ? S_WRITE : S_IDLE;
         end
         S_WRITE: state_n = (flush_pend || end_hit) ? S_IDLE : S_FILL;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         byte_addr  <= '0;
         data_q     <= '0;
         be_q       <= '0;
         waddr_q    <= '0;
         flush_pend <= 1'b0;
         end_hit    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state  <= state_n;
         done_q <= (state != S_IDLE) && (state_n == S_IDLE);
         case (state)
            S_IDLE: if (start) begin
               byte_addr  <= start_addr;
               data_q     <= '0;
               be_q       <= '0;
               flush_pend <= 1'b0;
               end_hit    <= 1'b0;
            end
            S_FILL: begin
               if (xfer) begin
                  data_q[lane*8 +: 8] <= byte_data;
                  be_q[lane]          <= 1'b1;
                  waddr_q             <= byte_addr[BYTE_ADDR_WIDTH-1:BYTES_PER_WORD_LOG2];
                  byte_addr           <= byte_addr + BYTE_ADDR_WIDTH'(1);
                  if (at_top) end_hit <= 1'b1;
               end
               if (flush && state_n == S_WRITE) flush_pend <= 1'b1;
            end
            S_WRITE: if (state_n == S_FILL) begin
               data_q <= '0;
               be_q   <= '0;
            end
            default: ;
         endcase
      end
   end

   assign byte_ready    = (state == S_FILL);
   assign word_we       = (state == S_WRITE);
   assign word_addr_out = word_we ? waddr_q : '0;
   assign word_data_out = word_we ? data_q  : '0;
   assign word_be       = word_we ? be_q    : '0;
   assign busy          = (state != S_IDLE);
   assign done          = done_q;

endmodule

// File: doc/byte_to_word_packer.md
Name: byte_to_word_packer

Overview:
- Write-side companion of the byte-read path. Takes a byte stream (e.g. program bytes arriving over UART) with a valid/ready handshake.
- Packs bytes little-endian into words and issues single-cycle word writes with byte enables into the word-organised instruction/data memory.
- Supports an unaligned start address, partial-word flush and termination at the top of memory.

Parameters:
- BYTE_ADDR_WIDTH, 6, width of byte-level address (64 bytes default).
- BYTES_PER_WORD, 4, bytes per word; must be a power of 2.
- BYTES_PER_WORD_LOG2 (local), $clog2(BYTES_PER_WORD), lane-select width.
- BITS_PER_WORD (local), 8*BYTES_PER_WORD, word width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a load session at start_addr (honoured only in IDLE).
- start_addr  in  BYTE_ADDR_WIDTH  first byte address of the session.
- flush  in  1  pulse; write out any partial word and end the session.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  incoming byte.
- byte_ready  out  1  packer accepts a byte this cycle (transfer = byte_valid & byte_ready).
- word_we  out  1  one-cycle word write strobe.
- word_addr_out  out  BYTE_ADDR_WIDTH-BYTES_PER_WORD_LOG2  word address of the write.
- word_data_out  out  BITS_PER_WORD  assembled word; unwritten lanes are 0.
- word_be  out  BYTES_PER_WORD  per-lane byte enable; lane i = bits [8i+7:8i].
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on the return to IDLE at session end.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - State IDLE.
  - byte_addr, word register, be register and all outputs = 0.
  - A partial word is discarded and never written.
- State IDLE:
  - byte_ready=0.
  - start -> byte_addr<=start_addr; be<=0; data<=0; go to FILL.
  - flush is ignored in IDLE.
- State FILL:
  - byte_ready=1.
  - On transfer: lane L=byte_addr[LOG2-1:0]; data[8L+:8]<=byte_data; be[L]<=1; word register address <= byte_addr[BYTE_ADDR_WIDTH-1:LOG2]; byte_addr<=byte_addr+1 (wraps modulo 2^BYTE_ADDR_WIDTH).
  - Go to WRITE if L==BYTES_PER_WORD-1, or if byte_addr was all-ones (end of memory).
  - flush in FILL:
    - Flush with a transfer in the same cycle: the byte is accepted first, then the flush applies.
    - After that, if any be bit is set (including the one just set), latch flush_pend and go to WRITE.
    - Otherwise go to IDLE and pulse done.
  - start in FILL or WRITE is ignored.
- State WRITE (exactly 1 cycle):
  - byte_ready=0; word_we=1; word_addr_out, word_data_out and word_be driven from the registers.
  - Latency: the write strobe occurs the cycle after the last byte of a word is accepted.
  - Next: if flush_pend or end-of-memory was hit -> IDLE, done=1 in the following cycle.
  - Otherwise -> FILL with be<=0 and data<=0.
- Output timing:
  - word_we, word_be and word_data_out are 0 outside WRITE.
  - done is a registered pulse, asserted the cycle IDLE is entered.
- Unaligned start: the first word has only lanes start_addr[LOG2-1:0]..BYTES_PER_WORD-1 enabled.
- Throughput: at most BYTES_PER_WORD bytes per BYTES_PER_WORD+1 cycles (one bubble per word).

Decomposition:
- No shared package needed.
- The state encoding (IDLE/FILL/WRITE) is a localparam set inside the module.
- Lane/word-address slicing is done inline; no sub-module.

Test Plan:
- start_addr=0, bytes 11,22,33,44 back-to-back -> one write at addr 0, data 0x44332211, be 1111; then FILL resumes with be cleared.
- start_addr=2, bytes AA,BB -> write addr 0, data 0xBBAA0000, be 1100, on the cycle after BB; the next byte lands in lane 0 of word 1.
- start_addr=8, byte 5A, then flush with no transfer -> write addr 2, data 0x0000005A, be 0001; done the next cycle; busy=0; byte_ready=0.
- start then immediate flush with no bytes -> no word_we; done pulse; IDLE. Simultaneous byte+flush on the 2nd byte -> both bytes are written (be 0011).
- start_addr=60, 4 bytes -> write addr 15, be 1111, then done and IDLE. A further byte_valid is not accepted.
- rst asserted after 3 of 4 bytes -> no word_we ever; all outputs 0 the next cycle. A new start at 0 packs cleanly, with no stale lanes.
